// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte queue and transmitter-launch signal bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clr_overflow;
    logic          idle;
    logic          TxD_start;
    logic [7:0]    TxD_data;
    logic          TxD_busy;

    // Producer and transmitter side: drives writes and reports transmitter busy
    modport master (
        output wr_en, wr_data, clr_overflow, TxD_busy,
        input  full, empty, level, overflow, idle, TxD_start, TxD_data
    );

    // FIFO side: accepts writes and launches characters
    modport slave (
        input  wr_en, wr_data, clr_overflow, TxD_busy,
        output full, empty, level, overflow, idle, TxD_start, TxD_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and one-character-at-a-time launch sequencer for async_transmitter
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [LW-1:0] level;
    logic [GW-1:0] gapCnt;
    logic          overflow;
    logic          txStart;
    logic [7:0]    txData;
    logic          full;
    logic          empty;
    logic          doPush;
    logic          doPop;

    // Full is judged on the pre-edge level, so a write at full is dropped even if a pop happens on the same edge
    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);
    assign doPush = bus.wr_en && !full;
    assign doPop  = (state == IDLE) && !empty && !bus.TxD_busy;

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.level     = level;
    assign bus.overflow  = overflow;
    assign bus.idle      = empty && (state == IDLE) && !bus.TxD_busy;
    assign bus.TxD_start = txStart;
    assign bus.TxD_data  = txData;

    // Queue storage; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag (a new drop beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            level <= level + LW'(doPush) - LW'(doPop);
            if (bus.wr_en && full) begin
                overflow <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Launch sequencer: pop, pulse start for one cycle, then track the transmitter's busy window and optional gap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            txStart <= 1'b0;
            txData  <= 8'h00;
            gapCnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (doPop) begin
                        txData  <= mem[rdPtr];
                        txStart <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    txStart <= 1'b0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.TxD_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.TxD_busy) begin
                        if (GAP_CYCLES > 0) begin
                            gapCnt <= GW'(GAP_CYCLES - 1);
                            state  <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gapCnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gapCnt <= gapCnt - GW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    txStart <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo with a behavioural transmitter
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(4))  ifA ();
    uart_tx_fifo_if #(.DEPTH(16)) ifB ();

    uart_tx_fifo #(.DEPTH(4),  .GAP_CYCLES(0)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    uart_tx_fifo #(.DEPTH(16), .GAP_CYCLES(5)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

    int nCompared   = 0;
    int nMismatched = 0;

    // edge index: at a posedge the old value is that edge's number; at a negedge it names the next edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter models: latch on a sampled start, stay busy 11 cycles, no reset
    logic [3:0] cntA = 4'd0;
    logic [3:0] cntB = 4'd0;
    logic forceA = 1'b0;
    assign ifA.TxD_busy = (cntA != 4'd0) || forceA;
    assign ifB.TxD_busy = (cntB != 4'd0);

    byte unsigned rxA[$];
    byte unsigned rxB[$];
    int riseA[$], fallA[$], riseB[$], fallB[$];
    int violA = 0;
    int violB = 0;

    always @(posedge clk) begin
        if (ifA.TxD_start && ifA.TxD_busy) violA <= violA + 1;
        if (cntA != 4'd0) begin
            cntA <= cntA - 4'd1;
            if (cntA == 4'd1) fallA.push_back(cyc);
        end else if (ifA.TxD_start && !forceA) begin
            cntA <= 4'd11;
            rxA.push_back(ifA.TxD_data);
            riseA.push_back(cyc - 1);
        end
    end

    always @(posedge clk) begin
        if (ifB.TxD_start && ifB.TxD_busy) violB <= violB + 1;
        if (cntB != 4'd0) begin
            cntB <= cntB - 4'd1;
            if (cntB == 4'd1) fallB.push_back(cyc);
        end else if (ifB.TxD_start) begin
            cntB <= 4'd11;
            rxB.push_back(ifB.TxD_data);
            riseB.push_back(cyc - 1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitIdle(input int which, input int budget, input string tag);
        int n = 0;
        while (n < budget && !((which == 0) ? ifA.idle : ifB.idle)) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " idle reached"}, (which == 0) ? ifA.idle : ifB.idle, 1);
    endtask

    task automatic clearA();
        rxA.delete();
        riseA.delete();
        fallA.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
        $fatal(1);
    end

    initial begin
        int pushEdge;
        int peak;
        int n;

        rst_n = 1'b0;
        ifA.wr_en = 1'b0; ifA.wr_data = 8'h00; ifA.clr_overflow = 1'b0;
        ifB.wr_en = 1'b0; ifB.wr_data = 8'h00; ifB.clr_overflow = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset level", ifA.level, 0);
        chk("reset empty", ifA.empty, 1);
        chk("reset full", ifA.full, 0);
        chk("reset overflow", ifA.overflow, 0);
        chk("reset TxD_start", ifA.TxD_start, 0);
        chk("reset TxD_data", ifA.TxD_data, 8'h00);
        chk("reset idle", ifA.idle, 1);
        rst_n = 1'b1;

        // single byte
        clearA();
        @(negedge clk);
        ifA.wr_data = 8'hA5; ifA.wr_en = 1'b1; pushEdge = cyc;
        @(negedge clk);
        ifA.wr_en = 1'b0;
        waitIdle(0, 60, "single");
        chk("single count", rxA.size(), 1);
        if (rxA.size() == 1) begin
            chk("single byte", rxA[0], 8'hA5);
            chk("single latency", riseA[0] - pushEdge, 1);
        end
        chk("single TxD_data held", ifA.TxD_data, 8'hA5);

        // burst of five
        clearA();
        peak = 0;
        @(negedge clk);
        ifA.wr_en = 1'b1; ifA.wr_data = 8'h01;
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            if (int'(ifA.level) > peak) peak = int'(ifA.level);
            if (i <= 5) ifA.wr_data = 8'(i);
            else ifA.wr_en = 1'b0;
        end
        chk("burst peak level", peak, 4);
        chk("burst full at peak", ifA.full, 1);
        waitIdle(0, 150, "burst");
        chk("burst count", rxA.size(), 5);
        chk("burst no overflow", ifA.overflow, 0);
        if (rxA.size() == 5 && fallA.size() >= 4) begin
            for (int i = 0; i < 5; i++) chk($sformatf("burst byte %0d", i), rxA[i], i + 1);
            for (int i = 1; i < 5; i++) chk($sformatf("burst spacing %0d", i), riseA[i] - fallA[i-1], 2);
        end

        // full and overflow with transmitter held busy
        clearA();
        @(negedge clk);
        forceA = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ifA.wr_en = 1'b1; ifA.wr_data = 8'h10 + 8'(i);
        end
        @(negedge clk);
        ifA.wr_en = 1'b0;
        chk("held level", ifA.level, 4);
        chk("held full", ifA.full, 1);
        chk("held overflow set", ifA.overflow, 1);
        chk("held nothing sent", rxA.size(), 0);
        ifA.wr_en = 1'b1; ifA.wr_data = 8'h77; ifA.clr_overflow = 1'b1;
        @(negedge clk);
        ifA.wr_en = 1'b0; ifA.clr_overflow = 1'b0;
        chk("overflow set beats clear", ifA.overflow, 1);
        ifA.clr_overflow = 1'b1;
        @(negedge clk);
        ifA.clr_overflow = 1'b0;
        chk("overflow cleared", ifA.overflow, 0);

        // release busy while writing at full: pop happens, write dropped
        forceA = 1'b0; ifA.wr_en = 1'b1; ifA.wr_data = 8'h55;
        @(negedge clk);
        ifA.wr_en = 1'b0;
        chk("full push+pop level", ifA.level, 3);
        chk("full push+pop overflow", ifA.overflow, 1);
        waitIdle(0, 200, "drain");
        chk("drain count", rxA.size(), 4);
        if (rxA.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("drain byte %0d", i), rxA[i], 8'h10 + i);

        // push and pop on the same edge at level 2
        clearA();
        @(negedge clk);
        forceA = 1'b1; ifA.wr_en = 1'b1; ifA.wr_data = 8'h21;
        @(negedge clk);
        ifA.wr_data = 8'h22;
        @(negedge clk);
        chk("pair level before", ifA.level, 2);
        forceA = 1'b0; ifA.wr_data = 8'h23;
        @(negedge clk);
        ifA.wr_en = 1'b0;
        chk("pair push+pop level", ifA.level, 2);
        waitIdle(0, 200, "pair");
        chk("pair count", rxA.size(), 3);
        if (rxA.size() == 3)
            for (int i = 0; i < 3; i++) chk($sformatf("pair byte %0d", i), rxA[i], 8'h21 + i);

        // inter-character gap on the second instance
        @(negedge clk);
        ifB.wr_en = 1'b1; ifB.wr_data = 8'h61; pushEdge = cyc;
        @(negedge clk);
        ifB.wr_data = 8'h62;
        @(negedge clk);
        ifB.wr_en = 1'b0;
        waitIdle(1, 150, "gap");
        chk("gap count", rxB.size(), 2);
        if (rxB.size() == 2 && fallB.size() >= 1) begin
            chk("gap byte 0", rxB[0], 8'h61);
            chk("gap byte 1", rxB[1], 8'h62);
            chk("gap first latency", riseB[0] - pushEdge, 1);
            chk("gap spacing", riseB[1] - fallB[0], 7);
        end

        // reset during the third data bit
        clearA();
        @(negedge clk);
        ifA.wr_en = 1'b1; ifA.wr_data = 8'h31;
        @(negedge clk);
        ifA.wr_data = 8'h32;
        @(negedge clk);
        ifA.wr_en = 1'b0;
        n = 0;
        while (cntA != 4'd8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("reached third data bit", cntA, 8);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset level", ifA.level, 0);
        chk("midreset empty", ifA.empty, 1);
        chk("midreset TxD_start", ifA.TxD_start, 0);
        chk("midreset idle while busy", ifA.idle, 0);
        n = 0;
        while (ifA.TxD_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("midreset busy dropped", ifA.TxD_busy, 0);
        repeat (4) @(negedge clk);
        chk("midreset no relaunch", rxA.size(), 1);
        ifA.wr_en = 1'b1; ifA.wr_data = 8'h4C;
        @(negedge clk);
        ifA.wr_en = 1'b0;
        waitIdle(0, 60, "after reset");
        chk("after reset count", rxA.size(), 2);
        if (rxA.size() == 2) begin
            chk("midreset first byte", rxA[0], 8'h31);
            chk("after reset byte", rxA[1], 8'h4C);
        end

        chk("A start while busy", violA, 0);
        chk("B start while busy", violB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
